// File: rtl/amiga_clk_pkg.sv
// Shared types and constants for the clock-enable generator and reset sequencer.
package amiga_clk_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2
  } clk_state_e;

  localparam int DEF_NCH         = 4;
  localparam int DEF_DW          = 8;
  localparam int DEF_LOCK_CYCLES = 1024;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/amiga_clken_div.sv
// One enable channel: phase counter plus shadow/active ratio pair that only swap at a period boundary.
module amiga_clken_div
  import amiga_clk_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_run,
  input  logic          i_run_nxt,
  input  logic          i_sync,
  input  logic [DW-1:0] i_div,
  input  logic          i_div_ld,
  output logic          o_en,
  output logic [DW-1:0] o_phase
);

  logic [DW-1:0] r_phase;
  logic [DW-1:0] r_active;
  logic [DW-1:0] r_shadow;
  logic          r_en;

  logic          w_wrap;
  logic          w_adv;
  logic [DW-1:0] w_phase_nxt;
  logic [DW-1:0] w_active_nxt;
  logic [DW-1:0] w_shadow_nxt;
  logic          w_en_nxt;

  // Outside RUN the counter sits at a boundary, so the active ratio tracks the shadow there;
  // this makes ratios loaded during reset take effect from the very first RUN period.
  always_comb begin
    w_wrap       = i_run && (r_phase == r_active);
    w_adv        = w_wrap || !i_run || i_sync;
    w_shadow_nxt = i_div_ld ? i_div : r_shadow;
    w_active_nxt = w_adv ? (i_div_ld ? i_div : r_shadow) : r_active;
    w_phase_nxt  = r_phase + DW'(1);
    if (!i_run_nxt || w_adv) w_phase_nxt = '0;
    // en is registered against the next phase so it coincides with phase==active
    w_en_nxt     = i_run_nxt && (w_phase_nxt == w_active_nxt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase  <= '0;
      r_active <= '1;
      r_shadow <= '1;
      r_en     <= 1'b0;
    end else begin
      r_phase  <= w_phase_nxt;
      r_active <= w_active_nxt;
      r_shadow <= w_shadow_nxt;
      r_en     <= w_en_nxt;
    end
  end

  assign o_en    = r_en & ~i_sync;
  assign o_phase = r_phase;

endmodule

// File: rtl/amiga_clken_gen.sv
// Lock-qualified reset sequencer and NCH phase-aligned clock-enable channels.
// Optional realign strobe support is compiled in with CLKEN_SYNC_EN.
module amiga_clken_gen
  import amiga_clk_pkg::*;
#(
  parameter int NCH         = DEF_NCH,
  parameter int DW          = DEF_DW,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pll_locked,
  input  logic [NCH*DW-1:0] div,
  input  logic [NCH-1:0]    div_ld,
  input  logic              sync_in,
  output logic [NCH-1:0]    en,
  output logic [NCH*DW-1:0] phase,
  output logic              sys_rst,
  output logic              ready,
  output clk_state_e        dbg_state
);

  localparam int LCW = (clog2(LOCK_CYCLES) < 1) ? 1 : clog2(LOCK_CYCLES);

  logic           r_lock_meta;
  logic           r_lock_sync;
  clk_state_e     r_state;
  clk_state_e     w_state_nxt;
  logic [LCW-1:0] r_lock_cnt;
  logic [LCW-1:0] w_lock_cnt_nxt;
  logic           r_sys_rst;
  logic           r_ready;
  logic           w_run;
  logic           w_run_nxt;
  logic           w_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock_meta <= 1'b0;
      r_lock_sync <= 1'b0;
      r_state     <= WAIT_LOCK;
      r_lock_cnt  <= '0;
      r_sys_rst   <= 1'b1;
      r_ready     <= 1'b0;
    end else begin
      r_lock_meta <= pll_locked;
      r_lock_sync <= r_lock_meta;
      r_state     <= w_state_nxt;
      r_lock_cnt  <= w_lock_cnt_nxt;
      // decoded from the next state so release lands on the same edge as RUN entry
      r_sys_rst   <= (w_state_nxt != RUN);
      r_ready     <= (w_state_nxt == RUN);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = '0;
    case (r_state)
      WAIT_LOCK: if (r_lock_sync) w_state_nxt = STABLE;
      STABLE: begin
        if (!r_lock_sync) w_state_nxt = WAIT_LOCK;
        else if (r_lock_cnt == LCW'(LOCK_CYCLES - 1)) w_state_nxt = RUN;
        else w_lock_cnt_nxt = r_lock_cnt + LCW'(1);
      end
      RUN:       if (!r_lock_sync) w_state_nxt = WAIT_LOCK;
      default:   w_state_nxt = WAIT_LOCK;
    endcase
  end

  assign w_run     = (r_state == RUN);
  assign w_run_nxt = (w_state_nxt == RUN);

`ifdef CLKEN_SYNC_EN
  assign w_sync = sync_in && w_run;
`else
  logic w_unused_sync;
  assign w_unused_sync = sync_in;
  assign w_sync        = 1'b0;
`endif

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    amiga_clken_div #(.DW(DW)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .i_run     (w_run),
      .i_run_nxt (w_run_nxt),
      .i_sync    (w_sync),
      .i_div     (div[g*DW +: DW]),
      .i_div_ld  (div_ld[g]),
      .o_en      (en[g]),
      .o_phase   (phase[g*DW +: DW])
    );
  end

  assign sys_rst   = r_sys_rst;
  assign ready     = r_ready;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_amiga_clken_gen.sv
// Directed bench for amiga_clken_gen: lock sequencing, enable cadence, ratio updates, realign.
module tb_amiga_clken_gen;
  import amiga_clk_pkg::*;

  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int LC  = 16;
  localparam int NV  = 41;

  logic              clk = 1'b0;
  logic              reset;
  logic              pll_locked;
  logic [NCH*DW-1:0] div;
  logic [NCH-1:0]    div_ld;
  logic              sync_in;
  logic [NCH-1:0]    en;
  logic [NCH*DW-1:0] phase;
  logic              sys_rst;
  logic              ready;
  clk_state_e        dbg_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NCH-1:0] ld;
    logic [DW-1:0]  d0;
    logic [NCH-1:0] exp_en;
    logic [NCH-1:0] en_mask;
    logic [DW-1:0]  exp_ph0;
  } vec_t;

  vec_t tbl[NV];

  always #5 clk = ~clk;

  amiga_clken_gen #(.NCH(NCH), .DW(DW), .LOCK_CYCLES(LC)) dut (
    .clk        (clk),
    .reset      (reset),
    .pll_locked (pll_locked),
    .div        (div),
    .div_ld     (div_ld),
    .sync_in    (sync_in),
    .en         (en),
    .phase      (phase),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .dbg_state  (dbg_state)
  );

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_en"}, 32'(en), 32'd0);
    chk({tag, "_phase"}, phase, 32'd0);
    chk({tag, "_sys_rst"}, 32'(sys_rst), 32'd1);
    chk({tag, "_ready"}, 32'(ready), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(WAIT_LOCK));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NCH-1:0] en_first[12];
    int ph;
    en_first = '{4'b0010, 4'b0110, 4'b1010, 4'b0111, 4'b0010, 4'b1110,
                 4'b0010, 4'b0111, 4'b1010, 4'b0110, 4'b0010, 4'b1111};
    for (int c = 0; c < NV; c++) begin
      tbl[c].ld      = '0;
      tbl[c].d0      = '0;
      tbl[c].en_mask = 4'b0011;
      if (c < 12) begin
        ph = c % 4;
        tbl[c].exp_en  = en_first[c];
        tbl[c].en_mask = 4'b1111;
      end else if (c < 16) begin
        ph = c % 4;
        tbl[c].exp_en = {2'b00, 1'b1, (ph == 3)};
      end else if (c < 32) begin
        ph = (c - 16) % 8;
        tbl[c].exp_en = {2'b00, 1'b1, (ph == 7)};
      end else begin
        ph = (c - 32) % 3;
        tbl[c].exp_en = {2'b00, 1'b1, (ph == 2)};
      end
      tbl[c].exp_ph0 = DW'(ph);
    end
    // ratio 7 loaded mid-period at phase 1, ratio 2 loaded on a wrap cycle
    tbl[13].ld = 4'b0001; tbl[13].d0 = 8'd7;
    tbl[31].ld = 4'b0001; tbl[31].d0 = 8'd2;

    reset = 1'b1; pll_locked = 1'b0; sync_in = 1'b0; div = '0; div_ld = '0;
    step(2);
    chk_reset_vals("rst");

    // ratios loaded while still in reset sequencing
    reset = 1'b0;
    div = {8'd2, 8'd1, 8'd0, 8'd3};
    div_ld = 4'hF;
    step();
    div_ld = '0;

    pll_locked = 1'b1;
    step(3);
    chk("lock_stable_state", 32'(dbg_state), 32'(STABLE));
    step(15);
    chk("lock_t18_sys_rst", 32'(sys_rst), 32'd1);
    step();
    chk("lock_t19_sys_rst", 32'(sys_rst), 32'd0);
    chk("lock_t19_ready", 32'(ready), 32'd1);
    chk("lock_t19_state", 32'(dbg_state), 32'(RUN));

    for (int k = 0; k < NV; k++) begin
      chk($sformatf("tbl_en[%0d]", k), 32'(en & tbl[k].en_mask), 32'(tbl[k].exp_en & tbl[k].en_mask));
      chk($sformatf("tbl_ph0[%0d]", k), 32'(phase[7:0]), 32'(tbl[k].exp_ph0));
      if (k < 12) chk($sformatf("tbl_ph1[%0d]", k), 32'(phase[15:8]), 32'd0);
      div[7:0] = tbl[k].d0;
      div_ld   = tbl[k].ld;
      step();
    end
    div_ld = '0;

    // lock loss in RUN
    pll_locked = 1'b0;
    step(2);
    chk("drop_t2_sys_rst", 32'(sys_rst), 32'd0);
    chk("drop_t2_en1", 32'(en[1]), 32'd1);
    step();
    chk("drop_t3_sys_rst", 32'(sys_rst), 32'd1);
    chk("drop_t3_ready", 32'(ready), 32'd0);
    chk("drop_t3_en", 32'(en), 32'd0);
    chk("drop_t3_phase", phase, 32'd0);
    step(2);
    chk("drop_t5_phase", phase, 32'd0);
    chk("drop_t5_state", 32'(dbg_state), 32'(WAIT_LOCK));

    // lock glitch during qualification
    pll_locked = 1'b1;
    step(3);
    chk("glitch_stable", 32'(dbg_state), 32'(STABLE));
    step(8);
    pll_locked = 1'b0;
    step(3);
    chk("glitch_back_wait", 32'(dbg_state), 32'(WAIT_LOCK));
    chk("glitch_sys_rst", 32'(sys_rst), 32'd1);
    step(2);
    pll_locked = 1'b1;
    step(18);
    chk("relock_t18_sys_rst", 32'(sys_rst), 32'd1);
    step();
    chk("relock_t19_sys_rst", 32'(sys_rst), 32'd0);
    chk("relock_t19_ready", 32'(ready), 32'd1);

    // reset mid-operation drops shadow ratios back to all-ones
    step(3);
    reset = 1'b1;
    step();
    chk_reset_vals("midrst");
    reset = 1'b0;
    step(18);
    chk("midrst_t18_sys_rst", 32'(sys_rst), 32'd1);
    step();
    chk("midrst_t19_sys_rst", 32'(sys_rst), 32'd0);
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("midrst_en[%0d]", c), 32'(en), 32'd0);
      chk($sformatf("midrst_ph0[%0d]", c), 32'(phase[7:0]), 32'(c));
      step();
    end

    // realign strobe
    reset = 1'b1;
    step();
    reset = 1'b0;
    div = {8'd255, 8'd9, 8'd0, 8'd5};
    div_ld = 4'hF;
    step();
    div_ld = '0;
    step(18);
    chk("sync_run_sys_rst", 32'(sys_rst), 32'd0);
    chk("sync_c0_ph0", 32'(phase[7:0]), 32'd0);
    div = {8'd255, 8'd1, 8'd0, 8'd5};
    div_ld = 4'b0100;
    step();
    div_ld = '0;
    step();
    chk("sync_c2_ph0", 32'(phase[7:0]), 32'd2);
    sync_in = 1'b1;
    #1;
`ifdef CLKEN_SYNC_EN
    chk("sync_c2_en1", 32'(en[1]), 32'd0);
`else
    chk("sync_c2_en1", 32'(en[1]), 32'd1);
`endif
    step();
    sync_in = 1'b0;
`ifdef CLKEN_SYNC_EN
    chk("sync_c3_ph0", 32'(phase[7:0]), 32'd0);
    chk("sync_c3_ph2", 32'(phase[23:16]), 32'd0);
    step();
    chk("sync_c4_en2", 32'(en[2]), 32'd1);
    step();
    chk("sync_c5_en0", 32'(en[0]), 32'd0);
    chk("sync_c5_ph0", 32'(phase[7:0]), 32'd2);
    step(3);
    chk("sync_c8_en0", 32'(en[0]), 32'd1);
    chk("sync_c8_ph0", 32'(phase[7:0]), 32'd5);
`else
    chk("sync_c3_ph0", 32'(phase[7:0]), 32'd3);
    chk("sync_c3_ph2", 32'(phase[23:16]), 32'd3);
    step();
    chk("sync_c4_en2", 32'(en[2]), 32'd0);
    step();
    chk("sync_c5_en0", 32'(en[0]), 32'd1);
    chk("sync_c5_ph0", 32'(phase[7:0]), 32'd5);
    step(3);
    chk("sync_c8_en0", 32'(en[0]), 32'd0);
    chk("sync_c8_ph0", 32'(phase[7:0]), 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
